// File: rtl/rdout_pkg.sv
// Shared types and phase constants for the readout sequencer and the
// trigger/L1A bookkeeping stage that it times.
package rdout_pkg;

    // Clocks per slot; STATE counts 0..NPHASE-1.
    localparam int NPHASE = 13;

    // Slot phases that the upstream stage also keys on.
    localparam logic [3:0] PH_CEW   = 4'd1;   // fifo write phase
    localparam logic [3:0] PH_CER   = 4'd3;   // fifo read phase (TRGDONE)
    localparam logic [3:0] PH_PBEND = 4'd12;  // last phase of a slot

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_READ  = 3'd2,
        ST_STALL = 3'd3,
        ST_DONE  = 3'd4
    } rdout_state_e;

    // Bitwise 2-of-3 majority, used to vote triplicated registers.
    function automatic logic [7:0] maj3(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rdout_seq_slot_timer.sv
// Slot phase counter. Counts 0..NPHASE-1 while run_i is high and flags the
// last phase of a slot. With TMR set the counter is held in three copies
// that are voted every clock, and each copy reloads from the voted value.
module slot_timer
    import rdout_pkg::*;
#(
    parameter int TMR    = 0,
    parameter int NPHASE = rdout_pkg::NPHASE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    output logic [3:0] state_o,
    output logic       slot_end_o
);

    localparam int         NC   = (TMR != 0) ? 3 : 1;
    localparam logic [3:0] LAST = 4'(NPHASE - 1);

    logic [3:0] ph_q [NC];
    logic [3:0] ph_v;
    logic [3:0] ph_d;

    generate
        if (TMR != 0) begin : g_vote
            // Majority of the three phase copies.
            always_comb ph_v = 4'(maj3(8'(ph_q[0]), 8'(ph_q[1]), 8'(ph_q[2])));
        end else begin : g_single
            // Single copy passes straight through.
            always_comb ph_v = ph_q[0];
        end
    endgenerate

    // Next phase: hold while stopped, wrap after the last phase.
    always_comb begin
        ph_d = ph_v;
        if (run_i) begin
            if (ph_v == LAST) ph_d = '0;
            else              ph_d = ph_v + 4'd1;
        end
    end

    // Phase register copies.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NC; k++) begin
            if (rst_i) ph_q[k] <= '0;
            else       ph_q[k] <= ph_d;
        end
    end

    assign state_o    = ph_v;
    assign slot_end_o = run_i && (ph_v == LAST);

endmodule

// File: rtl/rdout_seq.sv
// Readout sequencer. Walks one queued trigger event per pass: a header
// slot, then one slot per SCA sample (one or two blocks), then a done slot
// that pops the trigger fifo. All FSM moves happen at slot end only.
//
// Handshake: TEMPTY low means the head fifo entry is valid; the entry is
// consumed only by the single TRGDONE strobe (and its L1A number by the
// single POPL1AN strobe). FIFO_AFULL is a ready-low from the downstream data
// fifo, sampled only at slot end; it blocks event start and the next sample,
// never the done slot.
module rdout_seq
    import rdout_pkg::*;
#(
    parameter int TMR    = 0,
    parameter int NSAMP  = 8,
    parameter int NBLK   = 12,
    parameter int NPHASE = rdout_pkg::NPHASE
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             TEMPTY,
    input  logic             NOGTRG,
    input  logic             SCND_BLK,
    input  logic [3:0]       BLKOUT,
    input  logic [NSAMP-1:0] L1POUT,
    input  logic             FIFO_AFULL,
    output logic [3:0]       STATE,
    output logic             TRGDONE,
    output logic             POPL1AN,
    output logic             HDR,
    output logic             RDENA,
    output logic [6:0]       SCA_ADR,
    output logic             L1A_FLAG,
    output logic             BUSY,
    output rdout_state_e     DBG_FSM
);

    localparam int NC  = (TMR != 0) ? 3 : 1;
    localparam int SW  = $clog2(2 * NSAMP);
    localparam int SIW = $clog2(NSAMP);

    logic [3:0]       phase;
    logic             slot_end;

    rdout_state_e     fsm_q [NC];
    rdout_state_e     fsm_v;
    rdout_state_e     fsm_d;
    logic [SW-1:0]    smp_q [NC];
    logic [SW-1:0]    smp_v;
    logic [SW-1:0]    smp_d;
    logic [3:0]       blk_q;
    logic [3:0]       blk_d;

    logic [3:0]       ev_blk_q;
    logic             ev_scnd_q;
    logic             ev_nog_q;
    logic [NSAMP-1:0] ev_l1p_q;
    logic             latch_ev;

    logic             last_smp;
    logic [SIW-1:0]   idx;

    slot_timer #(
        .TMR    (TMR),
        .NPHASE (NPHASE)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .run_i      (RUN),
        .state_o    (phase),
        .slot_end_o (slot_end)
    );

    generate
        if (TMR != 0) begin : g_vote
            // Majority of the three FSM and sample-counter copies.
            always_comb begin
                fsm_v = rdout_state_e'(3'(maj3(8'(fsm_q[0]), 8'(fsm_q[1]), 8'(fsm_q[2]))));
                smp_v = SW'(maj3(8'(smp_q[0]), 8'(smp_q[1]), 8'(smp_q[2])));
            end
        end else begin : g_single
            // Single copies pass straight through.
            always_comb begin
                fsm_v = fsm_q[0];
                smp_v = smp_q[0];
            end
        end
    endgenerate

    assign idx      = smp_v[SIW-1:0];
    assign last_smp = (smp_v == (ev_scnd_q ? SW'(2 * NSAMP - 1) : SW'(NSAMP - 1)));

    // Next-state logic; everything holds except at slot end.
    always_comb begin
        fsm_d    = fsm_v;
        smp_d    = smp_v;
        blk_d    = blk_q;
        latch_ev = 1'b0;
        if (slot_end) begin
            unique case (fsm_v)
                ST_IDLE: begin
                    if (!TEMPTY && !FIFO_AFULL) begin
                        fsm_d    = ST_HDR;
                        latch_ev = 1'b1;
                    end
                end
                ST_HDR: begin
                    if (ev_nog_q) begin
                        fsm_d = ST_DONE;
                    end else begin
                        fsm_d = ST_READ;
                        smp_d = '0;
                        blk_d = ev_blk_q;
                    end
                end
                ST_READ: begin
                    // The last sample always retires, even under backpressure.
                    if (last_smp) begin
                        fsm_d = ST_DONE;
                    end else begin
                        fsm_d = FIFO_AFULL ? ST_STALL : ST_READ;
                        smp_d = smp_v + SW'(1);
                        if (smp_v == SW'(NSAMP - 1)) begin
                            blk_d = (blk_q == 4'(NBLK - 1)) ? 4'd0 : blk_q + 4'd1;
                        end
                    end
                end
                ST_STALL: begin
                    // Sample counter already points at the next sample.
                    if (!FIFO_AFULL) fsm_d = ST_READ;
                end
                ST_DONE: fsm_d = ST_IDLE;
                default: fsm_d = ST_IDLE;
            endcase
        end
    end

    // FSM, sample and block registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NC; k++) begin
                fsm_q[k] <= ST_IDLE;
                smp_q[k] <= '0;
            end
            blk_q <= '0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                fsm_q[k] <= fsm_d;
                smp_q[k] <= smp_d;
            end
            blk_q <= blk_d;
        end
    end

    // Event registers, loaded only when an event is accepted from IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ev_blk_q  <= '0;
            ev_scnd_q <= 1'b0;
            ev_nog_q  <= 1'b0;
            ev_l1p_q  <= '0;
        end else if (latch_ev) begin
            ev_blk_q  <= BLKOUT;
            ev_scnd_q <= SCND_BLK;
            ev_nog_q  <= NOGTRG;
            ev_l1p_q  <= L1POUT;
        end
    end

    // Output decode from FSM state and slot phase; strobes need RUN high.
    always_comb begin
        HDR      = 1'b0;
        RDENA    = 1'b0;
        TRGDONE  = 1'b0;
        POPL1AN  = 1'b0;
        SCA_ADR  = '0;
        L1A_FLAG = 1'b0;
        BUSY     = (fsm_v != ST_IDLE);
        unique case (fsm_v)
            ST_HDR: begin
                HDR     = 1'b1;
                POPL1AN = RUN && (phase == 4'd0);
            end
            ST_READ: begin
                RDENA    = RUN && (phase == 4'd0);
                SCA_ADR  = 7'(blk_q) * 7'(NSAMP) + 7'(idx);
                L1A_FLAG = ev_l1p_q[idx];
            end
            ST_DONE: TRGDONE = RUN && (phase == PH_CER);
            default: ;
        endcase
    end

    assign STATE   = phase;
    assign DBG_FSM = fsm_v;

endmodule

// File: tb/tb_rdout_seq.sv
// Directed bench for the readout sequencer: one task per scenario, each
// driving the trigger-fifo inputs and checking strobes, addresses and
// strobe timing against hand-computed values.
module tb_rdout_seq;
    import rdout_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic         CLK = 1'b0;
    logic         RST, RUN, TEMPTY, NOGTRG, SCND_BLK, FIFO_AFULL;
    logic [3:0]   BLKOUT;
    logic [7:0]   L1POUT;
    logic [3:0]   STATE;
    logic         TRGDONE, POPL1AN, HDR, RDENA, L1A_FLAG, BUSY;
    logic [6:0]   SCA_ADR;
    rdout_state_e dbg_fsm;

    always #5 CLK = ~CLK;

    rdout_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .RUN        (RUN),
        .TEMPTY     (TEMPTY),
        .NOGTRG     (NOGTRG),
        .SCND_BLK   (SCND_BLK),
        .BLKOUT     (BLKOUT),
        .L1POUT     (L1POUT),
        .FIFO_AFULL (FIFO_AFULL),
        .STATE      (STATE),
        .TRGDONE    (TRGDONE),
        .POPL1AN    (POPL1AN),
        .HDR        (HDR),
        .RDENA      (RDENA),
        .SCA_ADR    (SCA_ADR),
        .L1A_FLAG   (L1A_FLAG),
        .BUSY       (BUSY),
        .DBG_FSM    (dbg_fsm)
    );

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [6:0] exp_q[$];
    logic [6:0] adr_q[$];
    logic       flag_q[$];
    int         rd_cyc_q[$];
    int         pop_cyc_q[$];
    int         done_cyc_q[$];
    int         n_hdr_clk = 0;
    int         done_phase = -1;

    // ---------------- driver tasks ----------------
    // Advance to the next falling edge and record what the DUT shows there.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (RDENA) begin
            adr_q.push_back(SCA_ADR);
            flag_q.push_back(L1A_FLAG);
            rd_cyc_q.push_back(cyc);
        end
        if (POPL1AN) pop_cyc_q.push_back(cyc);
        if (TRGDONE) begin
            done_cyc_q.push_back(cyc);
            done_phase = int'(STATE);
        end
        if (HDR) n_hdr_clk++;
    endtask

    task automatic clear_obs();
        adr_q.delete();
        flag_q.delete();
        rd_cyc_q.delete();
        pop_cyc_q.delete();
        done_cyc_q.delete();
        exp_q.delete();
        n_hdr_clk  = 0;
        done_phase = -1;
    endtask

    // Present one event, scramble the inputs once it is latched, pop it on
    // TRGDONE, and optionally hold FIFO_AFULL for three slot ends starting
    // in the slot of sample stall_at.
    task automatic drive_event(input logic [3:0] blk, input logic scnd,
                               input logic [7:0] l1p, input logic nog,
                               input int stall_at);
        int stall_cnt;
        bit seen_done;
        bit finished;
        stall_cnt = -1;
        seen_done = 1'b0;
        finished  = 1'b0;
        clear_obs();
        BLKOUT = blk; SCND_BLK = scnd; L1POUT = l1p; NOGTRG = nog; TEMPTY = 1'b0;
        for (int t = 0; t < 600 && !finished; t++) begin
            tick();
            if (POPL1AN) begin
                BLKOUT = ~blk; SCND_BLK = ~scnd; L1POUT = ~l1p; NOGTRG = ~nog;
            end
            if (TRGDONE) begin
                seen_done = 1'b1;
                TEMPTY    = 1'b1;
            end
            if (stall_cnt >= 0 && FIFO_AFULL) begin
                stall_cnt++;
                if (stall_cnt == 39) FIFO_AFULL = 1'b0;
            end
            if (stall_at >= 0 && stall_cnt < 0 && RDENA && adr_q.size() == stall_at + 1) begin
                FIFO_AFULL = 1'b1;
                stall_cnt  = 0;
            end
            if (seen_done && !BUSY) finished = 1'b1;
        end
        FIFO_AFULL = 1'b0;
        n_vec++;
        if (!finished) begin
            n_err++;
            $display("FAIL event_timeout: got no completion (done=%0b busy=%0b) want TRGDONE then BUSY low", seen_done, BUSY);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1; RUN = 1'b1; TEMPTY = 1'b1; NOGTRG = 1'b0; SCND_BLK = 1'b0;
        BLKOUT = 4'd0; L1POUT = 8'h00; FIFO_AFULL = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if (STATE !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", STATE); end
        n_vec++;
        if (BUSY !== 1'b0 || dbg_fsm !== ST_IDLE) begin
            n_err++; $display("FAIL reset_busy: got busy=%b fsm=%0d want 0/IDLE", BUSY, dbg_fsm);
        end
        n_vec++;
        if ({HDR, RDENA, TRGDONE, POPL1AN, L1A_FLAG} !== 5'b00000) begin
            n_err++; $display("FAIL reset_strobes: got %b want 00000", {HDR, RDENA, TRGDONE, POPL1AN, L1A_FLAG});
        end
        n_vec++;
        if (SCA_ADR !== 7'd0) begin n_err++; $display("FAIL reset_adr: got %0d want 0", SCA_ADR); end
        RST = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            tick();
            n_vec++;
            if (STATE !== 4'(i % 13) || BUSY !== 1'b0) begin
                n_err++; $display("FAIL phase_count%0d: got state=%0d busy=%b want %0d/0", i, STATE, BUSY, i % 13);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] l1p;
        l1p = 8'h18;
        drive_event(4'd5, 1'b0, l1p, 1'b0, -1);
        n_vec++;
        if (adr_q.size() !== 8) begin n_err++; $display("FAIL single_count: got %0d want 8", adr_q.size()); end
        for (int i = 0; i < 8; i++) exp_q.push_back(7'(40 + i));
        for (int i = 0; i < 8 && i < adr_q.size(); i++) begin
            n_vec++;
            if (adr_q[i] !== exp_q[i] || flag_q[i] !== l1p[i]) begin
                n_err++; $display("FAIL single_s%0d: got adr=%0d flag=%b want adr=%0d flag=%b", i, adr_q[i], flag_q[i], exp_q[i], l1p[i]);
            end
        end
        n_vec++;
        if (pop_cyc_q.size() !== 1 || done_cyc_q.size() !== 1 || n_hdr_clk !== 13) begin
            n_err++; $display("FAIL single_strobes: got pop=%0d done=%0d hdr_clk=%0d want 1/1/13", pop_cyc_q.size(), done_cyc_q.size(), n_hdr_clk);
        end
        n_vec++;
        if (done_phase !== 3) begin n_err++; $display("FAIL single_done_phase: got %0d want 3", done_phase); end
        if (adr_q.size() == 8 && pop_cyc_q.size() == 1 && done_cyc_q.size() == 1) begin
            n_vec++;
            if (rd_cyc_q[0] - pop_cyc_q[0] !== 13 || done_cyc_q[0] - rd_cyc_q[7] !== 16) begin
                n_err++; $display("FAIL single_timing: got hdr->rd=%0d rd->done=%0d want 13/16", rd_cyc_q[0] - pop_cyc_q[0], done_cyc_q[0] - rd_cyc_q[7]);
            end
        end
        n_vec++;
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", BUSY); end
    endtask

    task automatic test_block_wrap();
        logic [7:0] l1p;
        l1p = 8'h81;
        drive_event(4'd11, 1'b1, l1p, 1'b0, -1);
        n_vec++;
        if (adr_q.size() !== 16) begin n_err++; $display("FAIL wrap_count: got %0d want 16", adr_q.size()); end
        for (int i = 0; i < 8; i++) exp_q.push_back(7'(88 + i));
        for (int i = 0; i < 8; i++) exp_q.push_back(7'(i));
        for (int i = 0; i < 16 && i < adr_q.size(); i++) begin
            n_vec++;
            if (adr_q[i] !== exp_q[i] || flag_q[i] !== l1p[i % 8]) begin
                n_err++; $display("FAIL wrap_s%0d: got adr=%0d flag=%b want adr=%0d flag=%b", i, adr_q[i], flag_q[i], exp_q[i], l1p[i % 8]);
            end
        end
        n_vec++;
        if (pop_cyc_q.size() !== 1 || done_cyc_q.size() !== 1) begin
            n_err++; $display("FAIL wrap_strobes: got pop=%0d done=%0d want 1/1", pop_cyc_q.size(), done_cyc_q.size());
        end
    endtask

    task automatic test_nogtrg();
        drive_event(4'd9, 1'b0, 8'hFF, 1'b1, -1);
        n_vec++;
        if (adr_q.size() !== 0) begin n_err++; $display("FAIL nogtrg_rdena: got %0d want 0", adr_q.size()); end
        n_vec++;
        if (pop_cyc_q.size() !== 1 || done_cyc_q.size() !== 1 || n_hdr_clk !== 13) begin
            n_err++; $display("FAIL nogtrg_strobes: got pop=%0d done=%0d hdr_clk=%0d want 1/1/13", pop_cyc_q.size(), done_cyc_q.size(), n_hdr_clk);
        end
        if (pop_cyc_q.size() == 1 && done_cyc_q.size() == 1) begin
            n_vec++;
            if (done_cyc_q[0] - pop_cyc_q[0] !== 16 || done_phase !== 3) begin
                n_err++; $display("FAIL nogtrg_timing: got hdr->done=%0d phase=%0d want 16/3", done_cyc_q[0] - pop_cyc_q[0], done_phase);
            end
        end
    endtask

    task automatic test_stall();
        drive_event(4'd2, 1'b0, 8'h01, 1'b0, 4);
        n_vec++;
        if (adr_q.size() !== 8) begin n_err++; $display("FAIL stall_count: got %0d want 8", adr_q.size()); end
        for (int i = 0; i < 8; i++) exp_q.push_back(7'(16 + i));
        for (int i = 0; i < 8 && i < adr_q.size(); i++) begin
            n_vec++;
            if (adr_q[i] !== exp_q[i] || flag_q[i] !== (i == 0)) begin
                n_err++; $display("FAIL stall_s%0d: got adr=%0d flag=%b want adr=%0d flag=%b", i, adr_q[i], flag_q[i], exp_q[i], (i == 0));
            end
        end
        for (int i = 1; i < 8 && i < rd_cyc_q.size(); i++) begin
            n_vec++;
            if (rd_cyc_q[i] - rd_cyc_q[i-1] !== ((i == 5) ? 52 : 13)) begin
                n_err++; $display("FAIL stall_gap%0d: got %0d want %0d", i, rd_cyc_q[i] - rd_cyc_q[i-1], (i == 5) ? 52 : 13);
            end
        end
    endtask

    task automatic test_afull_last();
        drive_event(4'd7, 1'b0, 8'h00, 1'b0, 7);
        n_vec++;
        if (adr_q.size() !== 8 || done_cyc_q.size() !== 1) begin
            n_err++; $display("FAIL afull_last_count: got rd=%0d done=%0d want 8/1", adr_q.size(), done_cyc_q.size());
        end
        if (adr_q.size() == 8 && done_cyc_q.size() == 1) begin
            n_vec++;
            if (adr_q[7] !== 7'd63 || done_cyc_q[0] - rd_cyc_q[7] !== 16) begin
                n_err++; $display("FAIL afull_last_done: got adr=%0d rd->done=%0d want 63/16", adr_q[7], done_cyc_q[0] - rd_cyc_q[7]);
            end
        end
    endtask

    task automatic test_run_hold();
        bit finished;
        bit seen_done;
        finished  = 1'b0;
        seen_done = 1'b0;
        clear_obs();
        BLKOUT = 4'd4; SCND_BLK = 1'b0; L1POUT = 8'h02; NOGTRG = 1'b0; TEMPTY = 1'b0;
        for (int t = 0; t < 400 && adr_q.size() < 2; t++) tick();
        n_vec++;
        if (adr_q.size() !== 2) begin n_err++; $display("FAIL hold_reach: got %0d reads want 2", adr_q.size()); end
        repeat (4) tick();
        RUN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if ({STATE, RDENA, TRGDONE, POPL1AN, HDR, BUSY, SCA_ADR, L1A_FLAG} !==
                {4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd33, 1'b1}) begin
                n_err++; $display("FAIL hold_c%0d: got state=%0d rd=%b busy=%b adr=%0d flag=%b want 4/0/1/33/1", i, STATE, RDENA, BUSY, SCA_ADR, L1A_FLAG);
            end
        end
        RUN = 1'b1;
        for (int t = 0; t < 400 && !finished; t++) begin
            tick();
            if (TRGDONE) begin seen_done = 1'b1; TEMPTY = 1'b1; end
            if (seen_done && !BUSY) finished = 1'b1;
        end
        n_vec++;
        if (!finished || adr_q.size() !== 8) begin
            n_err++; $display("FAIL hold_finish: got done=%b reads=%0d want 1/8", finished, adr_q.size());
        end
        if (adr_q.size() == 8) begin
            n_vec++;
            if (adr_q[7] !== 7'd39 || rd_cyc_q[2] - rd_cyc_q[1] !== 33) begin
                n_err++; $display("FAIL hold_resume: got last_adr=%0d gap=%0d want 39/33", adr_q[7], rd_cyc_q[2] - rd_cyc_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rst_cyc;
        clear_obs();
        BLKOUT = 4'd1; SCND_BLK = 1'b0; L1POUT = 8'h0F; NOGTRG = 1'b0; TEMPTY = 1'b0;
        for (int t = 0; t < 400 && adr_q.size() < 4; t++) tick();
        n_vec++;
        if (adr_q.size() !== 4) begin n_err++; $display("FAIL rstmid_reach: got %0d reads want 4", adr_q.size()); end
        repeat (2) tick();
        RST = 1'b1;
        tick();
        rst_cyc = cyc;
        RST = 1'b0;
        n_vec++;
        if (BUSY !== 1'b0 || STATE !== 4'd0 || HDR !== 1'b0 || SCA_ADR !== 7'd0) begin
            n_err++; $display("FAIL rstmid_idle: got busy=%b state=%0d hdr=%b adr=%0d want 0/0/0/0", BUSY, STATE, HDR, SCA_ADR);
        end
        n_vec++;
        if (done_cyc_q.size() !== 0) begin n_err++; $display("FAIL rstmid_nodone: got %0d want 0", done_cyc_q.size()); end
        drive_event(4'd1, 1'b0, 8'h0F, 1'b0, -1);
        n_vec++;
        if (adr_q.size() !== 8 || pop_cyc_q.size() !== 1) begin
            n_err++; $display("FAIL rstmid_replay: got reads=%0d pop=%0d want 8/1", adr_q.size(), pop_cyc_q.size());
        end
        if (adr_q.size() == 8 && pop_cyc_q.size() == 1) begin
            n_vec++;
            if (adr_q[0] !== 7'd8 || adr_q[7] !== 7'd15 || flag_q[3] !== 1'b1 || flag_q[4] !== 1'b0 || pop_cyc_q[0] - rst_cyc !== 13) begin
                n_err++; $display("FAIL rstmid_content: got a0=%0d a7=%0d f3=%b f4=%b rst->hdr=%0d want 8/15/1/0/13", adr_q[0], adr_q[7], flag_q[3], flag_q[4], pop_cyc_q[0] - rst_cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit finished;
        finished = 1'b0;
        clear_obs();
        BLKOUT = 4'd3; SCND_BLK = 1'b0; L1POUT = 8'h01; NOGTRG = 1'b0; TEMPTY = 1'b0;
        for (int t = 0; t < 900 && !finished; t++) begin
            tick();
            if (TRGDONE) begin
                if (done_cyc_q.size() == 1) begin BLKOUT = 4'd6; L1POUT = 8'h80; end
                else TEMPTY = 1'b1;
            end
            if (done_cyc_q.size() == 2 && !BUSY) finished = 1'b1;
        end
        n_vec++;
        if (!finished || pop_cyc_q.size() !== 2 || adr_q.size() !== 16) begin
            n_err++; $display("FAIL b2b_count: got fin=%b pop=%0d reads=%0d want 1/2/16", finished, pop_cyc_q.size(), adr_q.size());
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(7'(24 + i));
        for (int i = 0; i < 8; i++) exp_q.push_back(7'(48 + i));
        for (int i = 0; i < 16 && i < adr_q.size(); i++) begin
            n_vec++;
            if (adr_q[i] !== exp_q[i] || flag_q[i] !== (i == 0 || i == 15)) begin
                n_err++; $display("FAIL b2b_s%0d: got adr=%0d flag=%b want adr=%0d flag=%b", i, adr_q[i], flag_q[i], exp_q[i], (i == 0 || i == 15));
            end
        end
        if (pop_cyc_q.size() == 2 && done_cyc_q.size() == 2) begin
            n_vec++;
            if (pop_cyc_q[1] - done_cyc_q[0] !== 23) begin
                n_err++; $display("FAIL b2b_gap: got done->hdr=%0d want 23", pop_cyc_q[1] - done_cyc_q[0]);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single();
        test_block_wrap();
        test_nogtrg();
        test_stall();
        test_afull_last();
        test_run_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
